shiftreg_piso: RTL and testbench

- Parallel-in, serial-out word shift register; the inverse of the parallel tapped delay line.
- Accepts a packed vector of DEPTH words in one handshake, then emits the words one per accepted cycle on a valid/ready stream.
- Default order is highest-index word first, so feeding it the tap vector of a DEPTH-1 tapped delay line reproduces the original word stream oldest-first.
- Used for TDM-ing parallel filter/tap buses onto a narrow datapath.

---
 rtl/shiftreg_piso.sv | 88 ++++++++
 tb/tb_shiftreg_piso.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/shiftreg_piso.sv
// Parallel-in, serial-out word shift register with valid/ready handshakes.
// state | meaning
// IDLE  | no vector held; load_ready follows ena
// SHIFT | emitting words of the captured vector, one per output transfer
module shiftreg_piso #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 4,
    parameter int LSW_FIRST = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ena,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic [WIDTH*DEPTH-1:0] load_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_last
);
    localparam int TOTAL = WIDTH * DEPTH;
    localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W:0] LAST_IDX = (CNT_W + 1)'(DEPTH - 1);
    localparam logic [CNT_W:0] CNT_ONE  = (CNT_W + 1)'(1);
    localparam logic LOAD_LAST = (DEPTH == 1);

    if (WIDTH < 1) begin : g_bad_width
        $error("shiftreg_piso: WIDTH must be at least 1");
    end
    if (DEPTH < 1) begin : g_bad_depth
        $error("shiftreg_piso: DEPTH must be at least 1");
    end

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [TOTAL-1:0] word_buf;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   cnt_nxt;
    logic             take_load;
    logic             take_out;

    // word_buf holds the words not yet presented; the head is already in out_data
    function automatic logic [WIDTH-1:0] head(input logic [TOTAL-1:0] v);
        if (LSW_FIRST != 0) return v[WIDTH-1:0];
        else                return v[TOTAL-1 -: WIDTH];
    endfunction

    function automatic logic [TOTAL-1:0] advance(input logic [TOTAL-1:0] v);
        if (LSW_FIRST != 0) return v >> WIDTH;
        else                return v << WIDTH;
    endfunction

    assign load_ready = ena & ((state == IDLE) | (out_valid & out_last & out_ready));
    assign take_load  = load_valid & load_ready;
    assign take_out   = ena & out_valid & out_ready;
    assign cnt_nxt    = {1'b0, cnt} + CNT_ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            word_buf  <= '0;
            cnt       <= '0;
        end else if (take_load) begin
            // covers both a load from IDLE and the gap-free reload on the last word
            state     <= SHIFT;
            out_valid <= 1'b1;
            out_data  <= head(load_data);
            word_buf  <= advance(load_data);
            cnt       <= '0;
            out_last  <= LOAD_LAST;
        end else if (take_out) begin
            if (out_last) begin
                state     <= IDLE;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else begin
                out_data  <= head(word_buf);
                word_buf  <= advance(word_buf);
                cnt       <= cnt_nxt[CNT_W-1:0];
                out_last  <= (cnt_nxt == LAST_IDX);
            end
        end
    end
endmodule

// File: tb/tb_shiftreg_piso.sv
// Scoreboard bench for shiftreg_piso: MSW-first and LSW-first DEPTH=4 instances
// share one stimulus stream; a DEPTH=1 instance runs its own stream alongside.
module tb_shiftreg_piso;
    typedef struct {
        logic [15:0] data;
        logic        last;
    } item_t;

    logic        clk;
    logic        rst, ena, load_valid, out_ready;
    logic [63:0] load_data;
    logic        m_load_ready, m_out_valid, m_out_last;
    logic [15:0] m_out_data;
    logic        l_load_ready, l_out_valid, l_out_last;
    logic [15:0] l_out_data;

    logic        rst1, ena1, lv1, or1;
    logic [15:0] ld1;
    logic        d1_load_ready, d1_out_valid, d1_out_last;
    logic [15:0] d1_out_data;
    logic        d1_done;

    item_t q_m[$];
    item_t q_l[$];
    item_t q1[$];
    int    n_loads  = 0;
    int    n_loads1 = 0;
    int    checks   = 0;
    int    failures = 0;

    shiftreg_piso #(.WIDTH(16), .DEPTH(4), .LSW_FIRST(0)) u_msw (
        .clk(clk), .rst(rst), .ena(ena), .load_valid(load_valid), .load_ready(m_load_ready),
        .load_data(load_data), .out_valid(m_out_valid), .out_ready(out_ready),
        .out_data(m_out_data), .out_last(m_out_last));

    shiftreg_piso #(.WIDTH(16), .DEPTH(4), .LSW_FIRST(1)) u_lsw (
        .clk(clk), .rst(rst), .ena(ena), .load_valid(load_valid), .load_ready(l_load_ready),
        .load_data(load_data), .out_valid(l_out_valid), .out_ready(out_ready),
        .out_data(l_out_data), .out_last(l_out_last));

    shiftreg_piso #(.WIDTH(16), .DEPTH(1), .LSW_FIRST(0)) u_d1 (
        .clk(clk), .rst(rst1), .ena(ena1), .load_valid(lv1), .load_ready(d1_load_ready),
        .load_data(ld1), .out_valid(d1_out_valid), .out_ready(or1),
        .out_data(d1_out_data), .out_last(d1_out_last));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    assign ena1 = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Predictor: a vector is accepted on an edge when the model has nothing left to emit
    // at that edge (any word transferring on the same edge was popped at the prior negedge).
    always @(posedge clk) begin
        if (!rst && ena && load_valid && q_m.size() == 0) begin
            for (int k = 3; k >= 0; k--) q_m.push_back('{load_data[k*16 +: 16], k == 0});
            for (int k = 0; k < 4; k++)  q_l.push_back('{load_data[k*16 +: 16], k == 3});
            n_loads++;
        end
        if (!rst1 && lv1 && q1.size() == 0) begin
            q1.push_back('{ld1, 1'b1});
            n_loads1++;
        end
    end

    // Monitor: compare presented outputs with the queue heads, pop on output transfers.
    always @(negedge clk) begin
        if (!rst) begin
            chk("msw_load_ready", m_load_ready, ena && (q_m.size() == 0 || (q_m.size() == 1 && out_ready)));
            chk("msw_out_valid", m_out_valid, q_m.size() != 0);
            if (q_m.size() != 0) begin
                chk("msw_out_data", m_out_data, q_m[0].data);
                chk("msw_out_last", m_out_last, q_m[0].last);
                if (ena && out_ready) void'(q_m.pop_front());
            end else begin
                chk("msw_idle_last", m_out_last, 1'b0);
            end
            chk("lsw_load_ready", l_load_ready, ena && (q_l.size() == 0 || (q_l.size() == 1 && out_ready)));
            chk("lsw_out_valid", l_out_valid, q_l.size() != 0);
            if (q_l.size() != 0) begin
                chk("lsw_out_data", l_out_data, q_l[0].data);
                chk("lsw_out_last", l_out_last, q_l[0].last);
                if (ena && out_ready) void'(q_l.pop_front());
            end
        end
        if (!rst1) begin
            chk("d1_load_ready", d1_load_ready, q1.size() == 0 || or1);
            chk("d1_out_valid", d1_out_valid, q1.size() != 0);
            if (q1.size() != 0) begin
                chk("d1_out_data", d1_out_data, q1[0].data);
                chk("d1_out_last", d1_out_last, 1'b1);
                if (or1) void'(q1.pop_front());
            end
        end
    end

    task automatic send(input logic [63:0] d);
        int n0;
        n0 = n_loads;
        load_valid = 1'b1;
        load_data  = d;
        for (int i = 0; i < 50 && n_loads == n0; i++) step();
        chk("load_accepted", n_loads != n0, 1'b1);
        load_valid = 1'b0;
        load_data  = {$urandom, $urandom};
    endtask

    // DEPTH=1 stream: load_valid held high, data increments on every acceptance.
    initial begin
        int seen;
        seen = 0;
        rst1 = 1'b1; lv1 = 1'b0; ld1 = 16'h0100; or1 = 1'b1; d1_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst1 = 1'b0;
        lv1  = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (i >= 20) or1 = ($urandom_range(0, 3) != 0);
            step();
            if (n_loads1 != seen) begin
                seen = n_loads1;
                ld1  = ld1 + 16'd1;
            end
        end
        chk("d1_loads_min", n_loads1 >= 20, 1'b1);
        d1_done = 1'b1;
    end

    initial begin
        int n_before;
        rst = 1'b1; ena = 1'b1; load_valid = 1'b0; load_data = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_msw_valid", m_out_valid, 1'b0);
        chk("rst_msw_last", m_out_last, 1'b0);
        chk("rst_msw_data", m_out_data, 16'h0000);
        chk("rst_lsw_data", l_out_data, 16'h0000);
        chk("rst_d1_valid", d1_out_valid, 1'b0);
        step();
        rst = 1'b0;

        // directed vector, full throughput
        send(64'h0004_0003_0002_0001);
        repeat (6) step();

        // backpressure after the second word is presented
        send(64'h0004_0003_0002_0001);
        step();
        out_ready = 1'b0;
        repeat (3) step();
        chk("bp_data_held", m_out_data, 16'h0003);
        out_ready = 1'b1;
        repeat (5) step();

        // back-to-back vectors with load_valid held
        n_before = n_loads;
        send(64'hA003_A002_A001_A000);
        send(64'hB003_B002_B001_B000);
        chk("b2b_loads", n_loads - n_before, 2);
        repeat (6) step();

        // ena stall mid-vector, then asynchronous reset mid-vector
        send(64'hC003_C002_C001_C000);
        step();
        ena = 1'b0;
        repeat (2) step();
        chk("ena_hold_data", m_out_data, 16'hC002);
        ena = 1'b1;
        step();
        #2;
        rst = 1'b1;
        q_m.delete();
        q_l.delete();
        #1;
        chk("arst_valid", m_out_valid, 1'b0);
        chk("arst_data", m_out_data, 16'h0000);
        chk("arst_last", m_out_last, 1'b0);
        chk("arst_lsw_valid", l_out_valid, 1'b0);
        step();
        rst = 1'b0;
        send(64'hD003_D002_D001_D000);
        repeat (6) step();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            ena        = ($urandom_range(0, 9) != 0);
            out_ready  = ($urandom_range(0, 9) < 7);
            load_valid = $urandom_range(0, 1) == 1;
            load_data  = {$urandom, $urandom};
            step();
        end
        ena = 1'b1; out_ready = 1'b1; load_valid = 1'b0;
        repeat (6) step();
        chk("drain_empty", q_m.size(), 0);

        for (int i = 0; i < 2000 && !d1_done; i++) step();
        chk("d1_finished", d1_done, 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
